adder_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4-bit adder (5-bit sum, with propagation delay) between several requesters. It grants one requester at a time and drives that requester's registered operands onto the shared adder. It waits a fixed settle time for the adder output to become valid, then captures the sum and returns it with a one-cycle done pulse. It sits between the requesting blocks and a single adder instance.

---
 rtl/adder_share_arb_pkg.sv | 21 ++
 rtl/adder_share_arb_rr_pick.sv | 36 +++
 rtl/adder_share_arb.sv | 120 ++++++++++++
 tb/tb_adder_share_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM encoding, default
// widths and a small index-width helper.
package adder_share_arb_pkg;

    localparam int ADD_W          = 4;
    localparam int SUM_W          = ADD_W + 1;
    localparam int N_REQ_DEF      = 4;
    localparam int SETTLE_DEF     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Bits needed to index n items; never less than one so ports stay legal.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin picker. Searches last+1, last+2, ... with
// wrap-around and returns the first requester found.
module rr_pick
    import adder_share_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Walk the requesters starting just after the previous winner.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                winner_idx = cand;
            end
        end
        if (valid) begin
            winner_oh[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one combinational adder between
// N_REQ requesters: grant, hold operands for SETTLE_CYCLES, capture sum,
// pulse done for one cycle.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | no transaction; operands from last grant still driven
//   ST_SETTLE | operands held on the adder, waiting for the sum to settle
//   ST_RESP   | sum captured, done pulsing for the granted requester
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEF,
    parameter int W             = ADD_W,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic [W:0]         add_sum,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W:0]         rsp_sum,
    output logic               busy
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = idx_w(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_e       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic [W-1:0]     add_a_q;
    logic [W-1:0]     add_b_q;
    logic [W:0]       rsp_sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] last_q;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [W-1:0]     sel_a_d;
    logic [W-1:0]     sel_b_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last       (last_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // Operand slices of the requester the picker currently favours.
    always_comb begin
        sel_a_d = op_a[int'(pick_idx)*W +: W];
        sel_b_d = op_b[int'(pick_idx)*W +: W];
    end

    // Sequencer: grant, settle, capture, respond. Reset wins over everything,
    // so a transaction cut short by reset never reaches the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            rsp_sum_q <= '0;
            cnt_q     <= '0;
            last_q    <= LAST_RST;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_oh;
                        add_a_q <= sel_a_d;
                        add_b_q <= sel_b_d;
                        last_q  <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        rsp_sum_q <= add_sum;
                        done_q    <= gnt_q;
                        gnt_q     <= '0;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rsp_sum = rsp_sum_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with N_REQ=4, W=4, SETTLE_CYCLES=2.
// The shared adder is modelled as an ideal combinational adder.
module tb_adder_share_arb;

    localparam int N = 4;
    localparam int W = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W:0]     add_sum;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W:0]     rsp_sum;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    adder_share_arb #(
        .N_REQ         (N),
        .W             (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .gnt     (gnt),
        .done    (done),
        .rsp_sum (rsp_sum),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and check gnt/done exclusivity.
    task automatic tick();
        @(negedge clk);
        checks++;
        if ((gnt != '0 && done != '0) || !$onehot0(gnt) || !$onehot0(done)) begin
            errors++;
            $display("FAIL excl: got gnt=%b done=%b expected no overlap, one-hot", gnt, done);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_gnt",   32'(gnt),     32'd0);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_sum",   32'(rsp_sum), 32'd0);
        chk("rst_add_a", 32'(add_a),   32'd0);
        chk("rst_add_b", 32'(add_b),   32'd0);
    endtask

    // Wait for a grant, check it, then wait for done and check the response.
    task automatic run_txn(input logic [3:0] exp_gnt, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [4:0] es, input bit drop,
                           output int gwait, output int gcyc);
        int k;
        gwait = 0;
        do begin
            tick();
            gwait++;
        end while (gnt == '0 && gwait < 30);
        gcyc = cyc;
        chk("gnt",      32'(gnt),   32'(exp_gnt));
        chk("add_a",    32'(add_a), 32'(ea));
        chk("add_b",    32'(add_b), 32'(eb));
        chk("busy_on",  32'(busy),  32'd1);
        k = 0;
        do begin
            tick();
            k++;
        end while (done == '0 && k < 30);
        chk("done_lat", 32'(k),       32'(S));
        chk("done",     32'(done),    32'(exp_gnt));
        chk("rsp_sum",  32'(rsp_sum), 32'(es));
        chk("gnt_clr",  32'(gnt),     32'd0);
        if (drop) req = req & ~done;
    endtask

    initial begin
        int gw;
        int gc;
        int prev_gc;
        logic [3:0] oh;

        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;

        tbl[0] = '{idx: 1, a: 4'd3,  b: 4'd4,  sum: 5'd7};
        tbl[1] = '{idx: 3, a: 4'd15, b: 4'd15, sum: 5'd30};
        tbl[2] = '{idx: 0, a: 4'd0,  b: 4'd0,  sum: 5'd0};
        tbl[3] = '{idx: 2, a: 4'd9,  b: 4'd6,  sum: 5'd15};
        tbl[4] = '{idx: 0, a: 4'd15, b: 4'd1,  sum: 5'd16};
        tbl[5] = '{idx: 1, a: 4'd8,  b: 4'd8,  sum: 5'd16};

        do_reset();

        // Single requests, one at a time, including the 15+15 boundary.
        for (int v = 0; v < 6; v++) begin
            op_a = 16'hA5C3;
            op_b = 16'h3C5A;
            set_op(tbl[v].idx, tbl[v].a, tbl[v].b);
            oh = 4'(1 << tbl[v].idx);
            req = oh;
            run_txn(oh, tbl[v].a, tbl[v].b, tbl[v].sum, 1'b1, gw, gc);
            chk("gnt_lat", 32'(gw), 32'd1);
            tick();
            chk("resp_done_clr", 32'(done),  32'd0);
            chk("idle_busy",     32'(busy),  32'd0);
            chk("hold_add_a",    32'(add_a), 32'(tbl[v].a));
        end

        // Simultaneous requests after reset: requester 0 first, then 2.
        do_reset();
        set_op(0, 4'd7, 4'd8);
        set_op(2, 4'd15, 4'd1);
        req = 4'b0101;
        run_txn(4'b0001, 4'd7, 4'd8, 5'd15, 1'b1, gw, gc);
        chk("sim_lat0", 32'(gw), 32'd1);
        run_txn(4'b0100, 4'd15, 4'd1, 5'd16, 1'b1, gw, gc);
        chk("sim_lat2", 32'(gw), 32'd2);
        tick();
        chk("sim_idle", 32'(busy), 32'd0);

        // Fairness: all requests held, grants rotate every 4 cycles.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'(10 + i));
        req = 4'b1111;
        prev_gc = 0;
        for (int t = 0; t < 6; t++) begin
            int i;
            i = t % N;
            run_txn(4'(1 << i), 4'(i + 1), 4'(10 + i), 5'(11 + 2 * i), 1'b0, gw, gc);
            if (t > 0) chk("rr_spacing", 32'(gc - prev_gc), 32'(S + 2));
            prev_gc = gc;
        end
        req = '0;
        tick();
        tick();
        chk("rr_idle", 32'(busy), 32'd0);

        // Reset in the middle of SETTLE, on the edge that would raise done.
        set_op(2, 4'd5, 4'd6);
        req = 4'b0100;
        tick();
        chk("ab_gnt", 32'(gnt), 32'b0100);
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        chk("ab_gnt0",  32'(gnt),     32'd0);
        chk("ab_done0", 32'(done),    32'd0);
        chk("ab_busy0", 32'(busy),    32'd0);
        chk("ab_sum0",  32'(rsp_sum), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_nodone", 32'(done), 32'd0);
        end
        req = 4'b0100;
        run_txn(4'b0100, 4'd5, 4'd6, 5'd11, 1'b1, gw, gc);
        chk("ab_relat", 32'(gw), 32'd1);
        tick();

        // Operand change and req drop during SETTLE are ignored.
        set_op(3, 4'd2, 4'd3);
        req = 4'b1000;
        tick();
        chk("chg_gnt", 32'(gnt), 32'b1000);
        set_op(3, 4'd9, 4'd7);
        req = '0;
        begin
            int k;
            k = 0;
            do begin
                tick();
                k++;
            end while (done == '0 && k < 30);
            chk("chg_lat",  32'(k),       32'(S));
        end
        chk("chg_done",  32'(done),    32'b1000);
        chk("chg_sum",   32'(rsp_sum), 32'd5);
        tick();
        chk("chg_idle",  32'(busy),    32'd0);
        chk("chg_add_a", 32'(add_a),   32'd2);
        tick();
        chk("chg_nogrant", 32'(gnt),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
